// File: rtl/cpu_loader_if.sv
// Byte-stream and memory-write bundle for cpu_loader.
// master: the loader (consumes bytes, drives the write ports).
// slave : the host/memory side (drives bytes, observes the writes).
interface cpu_loader_if #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_data;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_wr_en;
  logic [DATA_WIDTH-1:0] imem_data;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic                  dmem_wr_en;
  logic [7:0]            dmem_data;

  modport master (
    input  in_valid, in_data,
    output in_ready,
    output imem_addr, imem_wr_en, imem_data,
    output dmem_addr, dmem_wr_en, dmem_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready,
    input  imem_addr, imem_wr_en, imem_data,
    input  dmem_addr, dmem_wr_en, dmem_data
  );
endinterface

// File: rtl/cpu_loader.sv
// cpu_loader: parses header/payload load packets from a byte stream, writes the
// instruction/data memories of cpu_top, and runs the CPU (start pulse, wait for done).
// Optional feature macro: CPU_LOADER_TIMEOUT_EN -- abort a run after TIMEOUT_CYCLES
// RUN cycles without cpu_done (timeout_err pulse). Without it RUN waits forever.
// Header byte: [7] target (0 imem, 1 dmem), [6:4] words-1, [3:0] start address.
module cpu_loader #(
  parameter int DATA_WIDTH     = 10,
  parameter int MEM_DEPTH      = 8,
  parameter int ADDR_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rstn,
  cpu_loader_if.master bus,
  input  logic         run,
  output logic         cpu_start,
  input  logic         cpu_done,
  output logic         busy,
  output logic         run_done,
  output logic         timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PAY_LO = 2'd1,
    ST_PAY_HI = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_rdy;        // stream may be accepted (0 in RUN and out of reset)
  logic                  r_tgt;        // 1 = data memory target
  logic [2:0]            r_cnt;        // words remaining minus 1
  logic [ADDR_WIDTH-1:0] r_addr;       // address of the next word
  logic [7:0]            r_lo;         // held low byte of an instruction word
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic                  r_imem_we;
  logic [DATA_WIDTH-1:0] r_imem_data;
  logic [ADDR_WIDTH-1:0] r_dmem_addr;
  logic                  r_dmem_we;
  logic [7:0]            r_dmem_data;
  logic                  r_start;      // also marks the first RUN cycle
  logic                  r_busy;
  logic                  r_run_done;
  logic                  r_terr;
`ifdef CPU_LOADER_TIMEOUT_EN
  logic [15:0]           r_tcnt;
`endif

  logic w_acc;

  // Next write address, wrapping from MEM_DEPTH-1 back to 0.
  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (a == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
      f_next_addr = '0;
    end else begin
      f_next_addr = a + ADDR_WIDTH'(1);
    end
  endfunction

  // run takes priority over the stream in IDLE, so ready drops that same cycle.
  assign bus.in_ready = r_rdy & ~((r_state == ST_IDLE) & run);
  assign w_acc        = bus.in_valid & bus.in_ready;

  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wr_en = r_imem_we;
  assign bus.imem_data  = r_imem_data;
  assign bus.dmem_addr  = r_dmem_addr;
  assign bus.dmem_wr_en = r_dmem_we;
  assign bus.dmem_data  = r_dmem_data;
  assign cpu_start      = r_start;
  assign busy           = r_busy;
  assign run_done       = r_run_done;
  assign timeout_err    = r_terr;

  // Loader FSM: packet parsing, registered memory writes and CPU run control.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_rdy       <= 1'b0;
      r_tgt       <= 1'b0;
      r_cnt       <= 3'd0;
      r_addr      <= '0;
      r_lo        <= 8'd0;
      r_imem_addr <= '0;
      r_imem_we   <= 1'b0;
      r_imem_data <= '0;
      r_dmem_addr <= '0;
      r_dmem_we   <= 1'b0;
      r_dmem_data <= 8'd0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_run_done  <= 1'b0;
      r_terr      <= 1'b0;
`ifdef CPU_LOADER_TIMEOUT_EN
      r_tcnt      <= 16'd0;
`endif
    end else begin
      // single-cycle pulses default low
      r_imem_we  <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_start    <= 1'b0;
      r_run_done <= 1'b0;
      r_terr     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (run) begin
            r_state <= ST_RUN;
            r_rdy   <= 1'b0;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
`ifdef CPU_LOADER_TIMEOUT_EN
            r_tcnt  <= 16'd0;
`endif
          end else if (w_acc) begin
            r_tgt   <= bus.in_data[7];
            r_cnt   <= bus.in_data[6:4];
            r_addr  <= bus.in_data[ADDR_WIDTH-1:0];
            r_state <= ST_PAY_LO;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_rdy   <= 1'b1;
          end
        end
        ST_PAY_LO: begin
          if (w_acc && r_tgt) begin
            r_dmem_we   <= 1'b1;
            r_dmem_addr <= r_addr;
            r_dmem_data <= bus.in_data;
            r_addr      <= f_next_addr(r_addr);
            if (r_cnt == 3'd0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt   <= r_cnt - 3'd1;
            end
          end else if (w_acc) begin
            r_lo    <= bus.in_data;
            r_state <= ST_PAY_HI;
          end else begin
            r_state <= ST_PAY_LO;
          end
        end
        ST_PAY_HI: begin
          if (w_acc) begin
            r_imem_we   <= 1'b1;
            r_imem_addr <= r_addr;
            r_imem_data <= {bus.in_data[DATA_WIDTH-9:0], r_lo};
            r_addr      <= f_next_addr(r_addr);
            if (r_cnt == 3'd0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt   <= r_cnt - 3'd1;
              r_state <= ST_PAY_LO;
            end
          end else begin
            r_state <= ST_PAY_HI;
          end
        end
        ST_RUN: begin
          // cpu_done during the start cycle is ignored
          if (!r_start && cpu_done) begin
            r_run_done <= 1'b1;
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_rdy      <= 1'b1;
          end
`ifdef CPU_LOADER_TIMEOUT_EN
          else if (r_tcnt == 16'(TIMEOUT_CYCLES - 1)) begin
            r_terr  <= 1'b1;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_rdy   <= 1'b1;
          end else begin
            r_tcnt  <= r_tcnt + 16'd1;
          end
`else
          else begin
            r_state <= ST_RUN;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_loader.sv
// Self-checking bench for cpu_loader: a packet model pushes expected memory
// writes into a scoreboard queue; a monitor pops and compares them.
module tb_cpu_loader;
  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int MD    = 8;
  localparam int TB_TO = 30;

  typedef struct {
    bit mem;   // 0 imem, 1 dmem
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rstn;
  logic run;
  logic cpu_start;
  logic cpu_done;
  logic busy;
  logic run_done;
  logic timeout_err;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  wr_t  sb[$];
  logic [7:0] pq[$];

  cpu_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cpu_loader #(
    .DATA_WIDTH(DW), .MEM_DEPTH(MD), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TB_TO)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .run(run), .cpu_start(cpu_start),
    .cpu_done(cpu_done), .busy(busy), .run_done(run_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // cycle counter used to time-stamp writes
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {1'b0, bus.in_ready, bus.imem_addr, bus.imem_wr_en, bus.imem_data,
              bus.dmem_addr, bus.dmem_wr_en, bus.dmem_data,
              cpu_start, busy, run_done, timeout_err}, 32'd0);
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (rstn) begin
      if (bus.imem_wr_en && bus.dmem_wr_en) begin
        chk("both_wr", 32'd1, 32'd0);
      end else if (bus.imem_wr_en || bus.dmem_wr_en) begin
        if (sb.size() == 0) begin
          chk("unexpected_wr", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wr_mem", {31'd0, bus.dmem_wr_en}, {31'd0, e.mem});
          chk("wr_addr", bus.dmem_wr_en ? 32'(bus.dmem_addr) : 32'(bus.imem_addr), e.addr);
          chk("wr_data", bus.dmem_wr_en ? 32'(bus.dmem_data) : 32'(bus.imem_data), e.data);
          chk("wr_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    chk("byte_ready", {31'd0, bus.in_ready}, 32'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  // Sends a header plus payload from pq and predicts the resulting writes.
  task automatic send_pkt(input logic [7:0] hdr);
    int c;
    int a;
    int n;
    logic [7:0] lo;
    logic [7:0] hi;
    send_byte(hdr, c);
    n = int'(hdr[6:4]) + 1;
    a = int'(hdr[3:0]) % MD;
    for (int w = 0; w < n; w++) begin
      if (hdr[7]) begin
        lo = pq.pop_front();
        send_byte(lo, c);
        sb.push_back('{1'b1, a, int'(lo), c + 1});
      end else begin
        lo = pq.pop_front();
        send_byte(lo, c);
        hi = pq.pop_front();
        send_byte(hi, c);
        sb.push_back('{1'b0, a, int'({hi[1:0], lo}), c + 1});
      end
      a = (a + 1) % MD;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic settle(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sb_empty"}, sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Run sequence: optional cpu_done in the start cycle (must be ignored), dly wait cycles.
  task automatic do_run(input int dly, input bit done_first);
    run = 1'b1;
    @(negedge clk);
    chk("run_rdy0", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    run      = 1'b0;
    cpu_done = done_first;
    @(negedge clk);
    chk("run_start", {29'd0, cpu_start, busy, bus.in_ready}, 32'b110);
    @(posedge clk);
    #1;
    cpu_done = 1'b0;
    run      = 1'b1;   // ignored while running
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("run_wait", {27'd0, cpu_start, busy, bus.in_ready, run_done, timeout_err}, 32'b01000);
    end
    @(posedge clk);
    #1;
    cpu_done = 1'b1;
    run      = 1'b0;
    @(negedge clk);
    chk("run_pre_done", {30'd0, run_done, busy}, 32'b01);
    @(posedge clk);
    #1;
    cpu_done = 1'b0;
    @(negedge clk);
    chk("run_done", {29'd0, run_done, busy, cpu_start}, 32'b100);
    @(negedge clk);
    chk("run_done_1cyc", {31'd0, run_done}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int c;
    rstn         = 1'b0;
    run          = 1'b0;
    cpu_done     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    #12;
    chk_zero("reset_outputs");
    #5;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // 1: data load
    pq = '{8'hAA, 8'hBB};
    send_pkt(8'h92);
    settle("t1");

    // 2: instruction load with wrap
    pq = '{8'h34, 8'h02, 8'hFF, 8'h01};
    send_pkt(8'h17);
    settle("t2");

    // full 8-word instruction packet, random bytes (upper bits ignored)
    pq.delete();
    for (int i = 0; i < 16; i++) pq.push_back(8'($urandom_range(0, 255)));
    send_pkt(8'h73);
    settle("t2b");

    // full 8-word data packet wrapping from address 6
    pq.delete();
    for (int i = 0; i < 8; i++) pq.push_back(8'($urandom_range(0, 255)));
    send_pkt(8'hF6);
    settle("t2c");

    // 3: runs, including cpu_done in the start cycle
    do_run(20, 1'b0);
    do_run(5, 1'b1);

    // 4: run and header together
    run          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h80;
    @(negedge clk);
    chk("t4_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    run          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_run", {29'd0, cpu_start, busy, bus.in_ready}, 32'b110);
    @(posedge clk);
    #1;
    cpu_done = 1'b1;
    @(posedge clk);
    #1;
    cpu_done = 1'b0;
    @(negedge clk);
    chk("t4_done", {31'd0, run_done}, 32'd1);
    @(posedge clk);
    #1;
    pq = '{8'h11, 8'h22};
    send_pkt(8'h91);
    settle("t4");

    // 5: reset mid-packet
    send_byte(8'h90, c);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_pre", {31'd0, busy}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk_zero("t5_rst_now");
    @(negedge clk);
    chk_zero("t5_rst_hold");
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    pq = '{8'h55, 8'h03};
    send_pkt(8'h81);
    settle("t5");

`ifdef CPU_LOADER_TIMEOUT_EN
    // 6: timeout
    run = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    for (int k = 0; k < TB_TO; k++) begin
      @(negedge clk);
      chk("t6_wait", {29'd0, busy, timeout_err, run_done}, 32'b100);
    end
    @(negedge clk);
    chk("t6_timeout", {29'd0, busy, timeout_err, run_done}, 32'b010);
    @(negedge clk);
    chk("t6_pulse", {31'd0, timeout_err}, 32'd0);
`else
    // 6: without the timeout feature a long run just keeps waiting
    do_run(2 * TB_TO, 1'b0);
`endif

    repeat (5) @(negedge clk);
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
